instr_fetch_stage: RTL and testbench

- Upstream neighbour of the 3-stage pipeline top: it produces the instr word that the decode/execute stages consume.
- Holds the PC and issues in-order requests to instruction memory over a req/gnt/rvalid interface.
- Buffers returned instructions with their PCs in a small FIFO and presents them downstream with a valid/ready handshake.
- Supports redirect (branch/jump flush) from later stages, discarding wrong-path data.

---
 rtl/instr_fetch_stage.sv | 121 ++++++++++++
 tb/tb_instr_fetch_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC generation, in-order imem request/response tracking
// and a small instruction buffer with redirect flush of wrong-path data.
module instr_fetch_stage #(
  parameter int                 XLEN       = 32,
  parameter logic [XLEN-1:0]    RESET_PC   = 32'h0000_0000,
  parameter int                 FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [XLEN-1:0]  instr_pc,
  input  logic             instr_ready,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] PC_INC = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [CW-1:0]   C_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]   P_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_out;
  logic [CW-1:0]   r_drop;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [31:0]     r_fifo_instr [FIFO_DEPTH];
  logic [XLEN-1:0] r_fifo_pc    [FIFO_DEPTH];

  logic [CW:0]     w_inflight;
  logic            w_req;
  logic            w_accept;
  logic            w_resp;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_out_after;
  logic [XLEN-1:0] w_redirect_pc;

  // Credits: every outstanding request must already own a buffer slot.
  assign w_inflight    = {1'b0, r_out} + {1'b0, r_count};
  assign w_req         = !rst && !redirect && (w_inflight < (CW+1)'(FIFO_DEPTH));
  assign w_accept      = w_req && imem_gnt;
  // A response with nothing outstanding is a leftover from before reset.
  assign w_resp        = imem_rvalid && (r_out != {CW{1'b0}});
  assign w_push        = w_resp && !redirect && (r_drop == {CW{1'b0}});
  assign w_pop         = (r_count != {CW{1'b0}}) && instr_ready && !redirect;
  assign w_out_after   = r_out + {{(CW-1){1'b0}}, w_accept} - {{(CW-1){1'b0}}, w_resp};
  assign w_redirect_pc = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};

  assign imem_req    = w_req;
  assign imem_addr   = r_fetch_pc;
  assign instr_valid = (r_count != {CW{1'b0}});

  // PC, credit, drop and buffer-occupancy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out      <= {CW{1'b0}};
      r_drop     <= {CW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_wptr     <= {AW{1'b0}};
      r_rptr     <= {AW{1'b0}};
    end else if (redirect) begin
      r_fetch_pc <= w_redirect_pc;
      r_resp_pc  <= w_redirect_pc;
      r_out      <= w_out_after;
      r_drop     <= w_out_after;
      r_count    <= {CW{1'b0}};
      r_wptr     <= {AW{1'b0}};
      r_rptr     <= {AW{1'b0}};
    end else begin
      r_out   <= w_out_after;
      r_count <= r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + PC_INC;
      end
      if (w_resp && (r_drop != {CW{1'b0}})) begin
        r_drop <= r_drop - C_ONE;
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + PC_INC;
        r_wptr    <= r_wptr + P_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + P_ONE;
      end
    end
  end

  // Buffer storage; contents are only observed while counted as valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wptr] <= imem_rdata;
      r_fifo_pc[r_wptr]    <= r_resp_pc;
    end
  end

  // Head of the buffer, zeroed as a pipeline bubble when empty.
  always_comb begin
    instr    = 32'h0000_0000;
    instr_pc = {XLEN{1'b0}};
    if (instr_valid) begin
      instr    = r_fifo_instr[r_rptr];
      instr_pc = r_fifo_pc[r_rptr];
    end else begin
      instr    = 32'h0000_0000;
      instr_pc = {XLEN{1'b0}};
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: a fixed vector table for reset and
// streaming, hand sequences for the corner cases and a randomized model-checked run.
module tb_instr_fetch_stage;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;

  instr_fetch_stage #(.XLEN(32), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: fetch/response PCs, credit counts and a queue of {pc, instr}.
  logic [31:0] m_fetch, m_resp;
  int          m_out, m_drop;
  logic [63:0] m_q[$];

  // Memory model: granted addresses in order with the earliest cycle they may return.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];
  bit    mem_drove;
  int    cyc = 0;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual %h required %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fetch = RPC;
    m_resp  = RPC;
    m_out   = 0;
    m_drop  = 0;
    m_q.delete();
    mem_q.delete();
  endtask

  task automatic mem_drive(input int pct);
    mem_drove = 1'b0;
    if (mem_q.size() > 0) begin
      if (mem_q[0].due <= cyc && $urandom_range(0, 99) < pct) mem_drove = 1'b1;
    end
    imem_rvalid = mem_drove;
    imem_rdata  = mem_drove ? mem_word(mem_q[0].addr) : $urandom;
  endtask

  // One clock: compare outputs with the model at negedge, advance the model at posedge.
  task automatic run_cycle();
    logic e_req, acc, rsp, e_val;
    logic [31:0] a;
    @(negedge clk);
    e_req = !rst && !redirect && (m_out + m_q.size() < DEPTH);
    e_val = (m_q.size() != 0);
    chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
    chk("imem_addr", imem_addr, m_fetch);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, e_val});
    chk("instr", instr, e_val ? m_q[0][31:0] : 32'd0);
    chk("instr_pc", instr_pc, e_val ? m_q[0][63:32] : 32'd0);
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
    s_pc = instr_pc; s_instr = instr;
    acc = e_req && imem_gnt;
    rsp = imem_rvalid && (m_out > 0);
    a   = m_fetch;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (acc) mem_q.push_back('{a, cyc + 1 + int'($urandom_range(0, 3))});
      if (imem_rvalid && mem_drove) void'(mem_q.pop_front());
      if (redirect) begin
        m_q.delete();
        m_fetch = {redirect_pc[31:2], 2'b00};
        m_resp  = m_fetch;
        if (rsp) m_out--;
        m_drop = m_out;
      end else begin
        if (instr_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (rsp) begin
          m_out--;
          if (m_drop > 0) m_drop--;
          else begin
            m_q.push_back({m_resp, imem_rdata});
            m_resp += 32'd4;
          end
        end
        if (acc) begin
          m_out++;
          m_fetch += 32'd4;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input logic g, input logic r, input logic rd, input logic [31:0] rpc, input int pct);
    imem_gnt = g; instr_ready = r; redirect = rd; redirect_pc = rpc;
    mem_drive(pct);
    run_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; mem_drove = 1'b0;
    redirect = 1'b0; instr_ready = 1'b0;
    model_reset();
    run_cycle();
    run_cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rst, gnt, rvalid, ready;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_pc;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int grants, n;
    bit first;
    logic [31:0] first_addr;

    // Reset release, ADD/SUB/XOR streaming, then a stray response with nothing outstanding.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0020_81B3, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h4020_8233, 1'b1, 32'h8, 1'b1, 32'h0020_81B3, 32'h0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0020_C2B3, 1'b1, 32'hC, 1'b1, 32'h4020_8233, 32'h4};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'hC, 1'b1, 32'h0020_C2B3, 32'h8};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hC, 1'b0, 32'h0, 32'h0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'hC, 1'b0, 32'h0, 32'h0};

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rvalid;
      imem_rdata = tbl[i].rdata; instr_ready = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("vec%0d_instr", i), instr, tbl[i].e_instr);
      chk($sformatf("vec%0d_pc", i), instr_pc, tbl[i].e_pc);
      @(posedge clk);
      #1;
    end

    // Backpressure: four credits, then stall; drain in order and resume at 0x10.
    do_reset();
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, 100);
      if (s_req && imem_gnt) grants++;
    end
    chk("bp_grants", grants, 32'd4);
    chk("bp_head_pc", s_pc, 32'h0);
    chk("bp_head_instr", s_instr, mem_word(32'h0));
    first = 1'b0; first_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'd0, 100);
      chk("bp_drain_pc", s_pc, 32'(4 * i));
      if (s_req && !first) begin first = 1'b1; first_addr = s_addr; end
    end
    chk("bp_resume_addr", first_addr, 32'h10);

    // Grant stall at 0x8 for three cycles.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 32'd0, 100);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 100);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'd0, 100);
      chk("stall_req", {31'd0, s_req}, 32'd1);
      chk("stall_addr", s_addr, 32'h8);
    end
    drive(1'b1, 1'b1, 1'b0, 32'd0, 100);
    drive(1'b0, 1'b1, 1'b0, 32'd0, 100);
    chk("stall_next_addr", s_addr, 32'hC);

    // Redirect with two requests outstanding: both responses are dropped.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 32'd0, 0);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 0);
    drive(1'b1, 1'b1, 1'b1, 32'h103, 0);
    chk("redir_req_low", {31'd0, s_req}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'd0, 100);
      if (i == 0) chk("redir_addr", s_addr, 32'h100);
      chk("redir_dropped", {31'd0, s_valid}, 32'd0);
    end
    chk("redir_drained", mem_q.size(), 32'd0);
    n = 0;
    do begin
      drive(1'b1, 1'b1, 1'b0, 32'd0, 100);
      n++;
    end while (!s_valid && n < 20);
    chk("redir_first_pc", s_pc, 32'h100);

    // PC wrap at the top of the address space.
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFA, 100);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 100);
    chk("wrap_a0", s_addr, 32'hFFFF_FFF8);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 100);
    chk("wrap_a1", s_addr, 32'hFFFF_FFFC);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 100);
    chk("wrap_a2", s_addr, 32'h0);

    // Asynchronous reset with three buffered entries, then a stray response.
    do_reset();
    n = 0;
    while (m_q.size() < 3 && n < 20) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, 100);
      n++;
    end
    chk("ar_fill", m_q.size(), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", {31'd0, instr_valid}, 32'd0);
    chk("ar_req", {31'd0, imem_req}, 32'd0);
    chk("ar_instr", instr, 32'd0);
    model_reset();
    imem_rvalid = 1'b0; mem_drove = 1'b0;
    run_cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 0);
    chk("ar_restart_addr", s_addr, RPC);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; mem_drove = 1'b0;
    run_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 0);
    chk("ar_stray_ignored", {31'd0, s_valid}, 32'd0);
    n = 0;
    do begin
      drive(1'b1, 1'b1, 1'b0, 32'd0, 100);
      n++;
    end while (!s_valid && n < 20);
    chk("ar_first_pc", s_pc, RPC);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 3, rpc, 70);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
